// File: rtl/ad1_pkg.sv
// Shared types and frame constants for the PmodAD1 (dual AD7476) serial reader.
package ad1_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_ZEROS = 4;
  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned RISE_CW    = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  function automatic logic lead_bits_set(input logic [FRAME_BITS-1:0] w);
    return |w[FRAME_BITS-1 -: LEAD_ZEROS];
  endfunction

endpackage

// File: rtl/ad1_spi_reader_if.sv
// ADC-side serial bus of the PmodAD1: chip select, serial clock and two data lines.
interface ad1_spi_reader_if;

  logic cs_n;
  logic sclk;
  logic sdata0;
  logic sdata1;

  modport master (output cs_n, sclk, input sdata0, sdata1);
  modport slave  (input cs_n, sclk, output sdata0, sdata1);

endinterface

// File: rtl/ad1_sclk_gen.sv
// Serial clock generator: while run is high, toggles sclk every CLK_DIV cycles
// (first edge falling) and stops after FRAME_BITS rising edges.
module ad1_sclk_gen
  import ad1_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               sclk,
  output logic               rise_stb,
  output logic               fall_stb,
  output logic [RISE_CW-1:0] rise_cnt,
  output logic               done
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]      r_div;
  logic               r_sclk;
  logic [RISE_CW-1:0] r_rises;
  logic               w_tick;

  // Gating the tick on done keeps sclk high after the last rise, even for CLK_DIV=1.
  assign done     = (r_rises == RISE_CW'(FRAME_BITS));
  assign w_tick   = run && !done && (r_div == DIV_LAST);
  assign rise_stb = w_tick && !r_sclk;
  assign fall_stb = w_tick && r_sclk;
  assign sclk     = r_sclk;
  assign rise_cnt = r_rises;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_sclk  <= 1'b1;
      r_rises <= '0;
    end else if (!run) begin
      r_div   <= '0;
      r_sclk  <= 1'b1;
      r_rises <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick)   r_sclk  <= ~r_sclk;
      if (rise_stb) r_rises <= r_rises + 1'b1;
    end
  end

endmodule

// File: rtl/ad1_spi_reader.sv
// PmodAD1 front end: periodic 16-bit dual-channel frames with a one-cycle valid strobe.
// Define AD1_LEADZERO_CHK_EN to drop frames whose four leading bits are not zero.
module ad1_spi_reader
  import ad1_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 2000,
  parameter int unsigned QUIET_CYC     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  ad1_spi_reader_if.master       spi,
  output logic [FRAME_BITS-1:0]  data0,
  output logic [FRAME_BITS-1:0]  data1,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   frame_err
);

  // QUIET plus the one IDLE cycle before the next start together give QUIET_CYC cs_n-high cycles.
  localparam int unsigned QUIET_LAST = (QUIET_CYC > 2) ? QUIET_CYC - 2 : 0;
  localparam int unsigned PER_LAST   = (SAMPLE_PERIOD > 1) ? SAMPLE_PERIOD - 1 : 0;

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_per;
  logic [31:0]           r_quiet;
  logic                  r_fresh;
  logic [FRAME_BITS-1:0] r_sh0;
  logic [FRAME_BITS-1:0] r_sh1;
  logic [FRAME_BITS-1:0] r_data0;
  logic [FRAME_BITS-1:0] r_data1;
  logic                  r_valid;
  logic                  w_run;
  logic                  w_sclk;
  logic                  w_rise;
  logic                  w_fall;
  logic [RISE_CW-1:0]    w_rise_cnt;
  logic                  w_done;
  logic                  w_start;
  logic                  w_finish;
  logic                  w_unused;

  assign w_run = (r_state == CONV);

  ad1_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (w_run),
    .sclk     (w_sclk),
    .rise_stb (w_rise),
    .fall_stb (w_fall),
    .rise_cnt (w_rise_cnt),
    .done     (w_done)
  );

  assign w_unused = ^{w_fall, w_rise_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (enable && (r_fresh || (r_per >= 32'(PER_LAST)))) w_next = CONV;
      CONV:    if (w_done) w_next = QUIET;
      QUIET:   if (r_quiet >= 32'(QUIET_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_start  = (r_state == IDLE) && (w_next == CONV);
  assign w_finish = (r_state == CONV) && w_done;

  // r_per holds cycles elapsed since the current frame's first cs_n-low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per   <= '0;
      r_quiet <= '0;
      r_fresh <= 1'b1;
    end else begin
      if (w_start)           r_per <= '0;
      else if (r_per != '1)  r_per <= r_per + 1'b1;
      r_quiet <= (r_state == QUIET) ? r_quiet + 1'b1 : '0;
      if (!enable)           r_fresh <= 1'b1;
      else if (w_start)      r_fresh <= 1'b0;
    end
  end

`ifdef AD1_LEADZERO_CHK_EN
  logic r_err;
  logic w_bad;

  assign w_bad     = lead_bits_set(r_sh0) || lead_bits_set(r_sh1);
  assign frame_err = r_err;
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_valid <= 1'b0;
`ifdef AD1_LEADZERO_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef AD1_LEADZERO_CHK_EN
      r_err   <= 1'b0;
`endif
      if (w_rise) begin
        r_sh0 <= {r_sh0[FRAME_BITS-2:0], spi.sdata0};
        r_sh1 <= {r_sh1[FRAME_BITS-2:0], spi.sdata1};
      end
      if (w_finish) begin
`ifdef AD1_LEADZERO_CHK_EN
        if (w_bad) begin
          r_err <= 1'b1;
        end else begin
          r_data0 <= r_sh0;
          r_data1 <= r_sh1;
          r_valid <= 1'b1;
        end
`else
        r_data0 <= r_sh0;
        r_data1 <= r_sh1;
        r_valid <= 1'b1;
`endif
      end
    end
  end

  assign spi.cs_n   = (r_state != CONV);
  assign spi.sclk   = w_sclk;
  assign busy       = (r_state == CONV);
  assign data0      = r_data0;
  assign data1      = r_data1;
  assign data_valid = r_valid;

endmodule

// File: doc/ad1_spi_reader.md
Name: ad1_spi_reader

Overview:
- Serial front end for the PmodAD1 (dual AD7476, 12-bit) sensor path.
- Drives cs_n and sclk, shifts in both SDATA lines at a fixed sample rate, and presents raw 16-bit frames plus a one-cycle valid strobe.
- Its data0/data1 outputs are the DATA words consumed by the per-drum threshold/level detector downstream.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; minimum 1.
- SAMPLE_PERIOD, 2000: clk cycles between consecutive frame starts.
- QUIET_CYC, 8: minimum clk cycles cs_n stays high after a frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = free-run conversions
- sdata0  in  1  ADC channel 0 serial data
- sdata1  in  1  ADC channel 1 serial data
- cs_n  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock, idles high
- data0  out  16  last complete channel-0 frame, MSB first as received
- data1  out  16  last complete channel-1 frame
- data_valid  out  1  one-cycle pulse when data0/data1 update
- busy  out  1  high while cs_n low
- frame_err  out  1  one-cycle pulse on leading-zero violation; see Optional Feature

Behaviour:
- Reset, async on rst_n low:
  - cs_n=1, sclk=1, data0=data1=0, data_valid=0, busy=0, frame_err=0.
  - State IDLE; all counters 0.
- FSM states: IDLE, CONV, QUIET.
- Transitions:
  - IDLE -> CONV when enable=1 and the period counter has expired. The first frame after reset or enable rise starts on the next cycle.
  - CONV -> QUIET after the 16th sample.
  - QUIET -> IDLE after QUIET_CYC cycles.
- Frame timing, with T0 = cycle cs_n goes low and busy goes high:
  - sclk toggles every CLK_DIV cycles; first falling edge at T0+CLK_DIV.
  - Rising edge k (k=1..16) at T0+2k*CLK_DIV.
  - sdata0/sdata1 are sampled on the clk edge that raises sclk, and shifted left into shadow registers (first bit becomes bit 15).
- Completion, at cycle T0+32*CLK_DIV+1: cs_n=1, sclk=1, busy=0, data0/data1 load from the shadows, data_valid=1 for exactly that cycle.
- Period counter:
  - Restarts at T0.
  - Next T0 = max(T0+SAMPLE_PERIOD, end of QUIET).
  - If SAMPLE_PERIOD < 32*CLK_DIV+1+QUIET_CYC, frames run back-to-back, limited by QUIET. No error is raised.
- enable dropped mid-frame: the current frame completes normally (valid pulses), then the block holds in IDLE. No partial frames are ever emitted.
- enable re-asserted: a frame starts within 1 cycle once QUIET has finished.
- Reset mid-frame: immediate return to reset values. Shadow contents are discarded and data0/data1 do not update.
- data0/data1 hold their value between valid pulses. No downstream backpressure; the consumer samples on data_valid.

Optional Feature:
- Macro AD1_LEADZERO_CHK_EN.
- Defined: at completion, if shadow bits [15:12] of either channel are nonzero:
  - data0/data1 are not updated and data_valid stays 0;
  - frame_err pulses 1 cycle instead.
- Undefined: frame_err is tied 0 and every frame is delivered unchanged.

Decomposition:
- Package ad1_pkg:
  - state enum {IDLE, CONV, QUIET};
  - FRAME_BITS=16, LEAD_ZEROS=4, ADC_BITS=12.
- Sub-module ad1_sclk_gen, parameterised by CLK_DIV:
  - inputs: run (level);
  - outputs: sclk, rise_stb, fall_stb, plus a rise counter reporting 16 rises.
  - The top-level FSM owns cs_n, the shift registers and the period counter.

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=100, QUIET_CYC=4; ADC model shifts 16'h0ABC on sdata0 and 16'h0123 on sdata1 -> data0=16'h0ABC, data1=16'h0123, data_valid high only at T0+65, exactly 16 sclk rising edges, cs_n high at T0+65.
- Same config, enable held 1 for 500 cycles -> 5 valid pulses spaced exactly 100 cycles apart; cs_n low for 65 cycles each frame.
- SAMPLE_PERIOD=10 (below frame length) -> consecutive T0 spacing = 65+4 = 69 cycles; no overlap; sclk idles high between frames.
- enable dropped at T0+20 -> frame completes, valid pulses at T0+65; no further cs_n activity until enable returns.
- rst_n pulsed low at T0+30 -> cs_n=1, sclk=1 asynchronously; data0/data1=0; no valid pulse; after release the next frame starts cleanly.
- With AD1_LEADZERO_CHK_EN, sdata0 = 16'h8ABC -> frame_err pulse at T0+65, data0/data1 retain their previous values, no data_valid. Without the macro -> data0=16'h8ABC delivered with valid, frame_err stays 0.
